prog_counter: RTL

//   Program counter and fetch sequencer for the 8-bit core. It holds the current

---
 rtl/prog_counter_if.sv | 27 ++
 rtl/prog_counter.sv | 77 +++++++
 2 files changed

// File: rtl/prog_counter_if.sv
// Fetch-sequencer bus: the control inputs that steer the program counter,
// plus the address, status and retired-count outputs it returns.
interface prog_counter_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stall;
    logic             branch_taken;
    logic [PC_W-1:0]  target;
    logic             halt_req;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_plus1;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output start, stall, branch_taken, target, halt_req,
        input  pc, pc_plus1, running, done, instr_cnt
    );

    modport slave (
        input  start, stall, branch_taken, target, halt_req,
        output pc, pc_plus1, running, done, instr_cnt
    );
endinterface

// File: rtl/prog_counter.sv
// Program counter and IDLE/RUN/HALT fetch sequencer for the 8-bit core,
// with a saturating retired-instruction counter.
module prog_counter #(
    parameter int PC_W       = 8,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input logic          clk,
    input logic          reset,
    prog_counter_if.slave bus
);
    localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_reg;
    logic [PC_W-1:0]  pc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             running_reg;
    logic             done_reg;
    logic [CNT_W-1:0] cnt_next;

    // Counter sticks at its maximum rather than wrapping back to zero.
    assign cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            pc_reg      <= START_PC;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, HALT: begin
                    if (bus.start) begin
                        state_reg   <= RUN;
                        pc_reg      <= START_PC;
                        cnt_reg     <= '0;
                        running_reg <= 1'b1;
                        done_reg    <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.halt_req) begin
                        state_reg   <= HALT;
                        cnt_reg     <= cnt_next;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b1;
                    end else if (!bus.stall) begin
                        // A stall suppresses a pending branch as well as the increment.
                        pc_reg  <= bus.branch_taken ? bus.target : pc_reg + PC_W'(1);
                        cnt_reg <= cnt_next;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    pc_reg      <= START_PC;
                    cnt_reg     <= '0;
                    running_reg <= 1'b0;
                    done_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = pc_reg;
    assign bus.pc_plus1  = pc_reg + PC_W'(1);
    assign bus.running   = running_reg;
    assign bus.done      = done_reg;
    assign bus.instr_cnt = cnt_reg;
endmodule
